// File: rtl/uart_tx_arbiter_pkg.sv
// Shared state encoding, requester-count limits and index helpers for uart_tx_arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 4;
  localparam int IDX_W     = 2;

  // Successor of a requester index, wrapping at the number of requesters.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input int n_req);
    logic [IDX_W-1:0] nxt;
    if (int'(idx) + 1 >= n_req) nxt = '0;
    else                        nxt = idx + 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side stream signals of uart_tx_arbiter.
// "slave" is the arbiter's view; "master" is the view of the requesters plus the UART sink.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 3
) ();

  logic [N_REQ-1:0]   s_tvalid;
  logic [N_REQ-1:0]   s_tready;
  logic [8*N_REQ-1:0] s_tdata;
  logic [N_REQ-1:0]   s_tlast;
  logic               o_tvalid;
  logic               o_tready;
  logic [7:0]         o_tdata;
  logic [IDX_W-1:0]   o_grant;
  logic               o_busy;
  logic               o_timeout;

  modport slave (
    input  s_tvalid, s_tdata, s_tlast, o_tready,
    output s_tready, o_tvalid, o_tdata, o_grant, o_busy, o_timeout
  );

  modport master (
    output s_tvalid, s_tdata, s_tlast, o_tready,
    input  s_tready, o_tvalid, o_tdata, o_grant, o_busy, o_timeout
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr_i, else the lowest one below it.
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Scanning downward lets the lowest matching index in each half win.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        if (IDX_W'(i) >= ptr_i) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(i);
        end
      end
    end
    found_o = hi_found | lo_found;
    idx_o   = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter merging N_REQ byte streams into one UART transmit stream, whole messages at a time.
// Optional stall timeout enabled by defining UART_TX_ARBITER_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int          N_REQ          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_arbiter_if.slave bus
);

  if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX) begin : g_bad_n_req
    $error("uart_tx_arbiter: N_REQ=%0d is outside %0d..%0d", N_REQ, N_REQ_MIN, N_REQ_MAX);
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic             tvalid_q, tvalid_d;
  logic [7:0]       tdata_q, tdata_d;

  logic [3:0]       req_pad;
  logic [3:0]       last_pad;
  logic [31:0]      data_pad;
  logic             req_g;
  logic             last_g;
  logic [7:0]       data_g;
  logic             slot_free;
  logic             accept;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] ready_vec;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  logic [31:0]      stall_q, stall_d;
  logic             timeout_q, timeout_d;
`endif

  // Padding to the maximum width keeps the grant-indexed selects in range for any N_REQ.
  assign req_pad   = 4'(bus.s_tvalid);
  assign last_pad  = 4'(bus.s_tlast);
  assign data_pad  = 32'(bus.s_tdata);
  assign req_g     = req_pad[grant_q];
  assign last_g    = last_pad[grant_q];
  assign data_g    = data_pad[{grant_q, 3'b000} +: 8];
  assign slot_free = ~tvalid_q | bus.o_tready;
  assign accept    = (state_q == S_GRANT) & req_g & slot_free;

  rr_pick #(
    .N(N_REQ)
  ) u_rr_pick (
    .req_i  (bus.s_tvalid),
    .ptr_i  (rr_ptr_q),
    .found_o(pick_found),
    .idx_o  (pick_idx)
  );

  always_comb begin
    ready_vec = '0;
    if (state_q == S_GRANT) begin
      for (int i = 0; i < N_REQ; i++) begin
        ready_vec[i] = slot_free & (IDX_W'(i) == grant_q);
      end
    end
  end

  // Single-entry output register; the held byte drains independently of the FSM.
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    if (accept) begin
      tvalid_d = 1'b1;
      tdata_d  = data_g;
    end else if (bus.o_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    stall_d   = stall_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        stall_d = '0;
`endif
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (accept) begin
`ifdef UART_TX_ARBITER_TIMEOUT_EN
          stall_d = '0;
`endif
          if (last_g) begin
            state_d  = S_IDLE;
            rr_ptr_d = next_idx(grant_q, N_REQ);
          end
        end
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        else if (!req_g) begin
          stall_d = stall_q + 32'd1;
          if (stall_d >= TIMEOUT_CYCLES) begin
            state_d   = S_IDLE;
            rr_ptr_d  = next_idx(grant_q, N_REQ);
            timeout_d = 1'b1;
            stall_d   = '0;
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
    end
  end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.o_timeout = timeout_q;
`else
  assign bus.o_timeout = 1'b0;
`endif

  assign bus.s_tready = ready_vec;
  assign bus.o_tvalid = tvalid_q;
  assign bus.o_tdata  = tdata_q;
  assign bus.o_grant  = grant_q;
  assign bus.o_busy   = (state_q == S_GRANT);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a message-level reference model checked every cycle,
// and directed scenarios with hand-computed byte and grant sequences.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(
    .N_REQ         (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Requester message stores: {tlast, data} per entry, consumed on handshake.
  logic [8:0]   msg [N][32];
  int           wr  [N];
  int           rd  [N];
  logic [N-1:0]   drv_v, drv_l;
  logic [8*N-1:0] drv_d;

  task automatic enq(input int r, input logic [7:0] d, input bit last);
    msg[r][wr[r]] = {last, d};
    wr[r]++;
  endtask

  always begin
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (!rst && bus.s_tvalid[i] && bus.s_tready[i]) rd[i]++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd[i] < wr[i]) begin
        drv_v[i]         = 1'b1;
        drv_d[i*8 +: 8]  = msg[i][rd[i]][7:0];
        drv_l[i]         = msg[i][rd[i]][8];
      end else begin
        drv_v[i]         = 1'b0;
        drv_d[i*8 +: 8]  = 8'h00;
        drv_l[i]         = 1'b0;
      end
    end
    bus.s_tvalid = drv_v;
    bus.s_tdata  = drv_d;
    bus.s_tlast  = drv_l;
  end

  // Reference model: message-level round robin with a one-byte output buffer.
  bit         m_busy = 1'b0, m_ov = 1'b0, m_to = 1'b0;
  int         m_grant = 0, m_ptr = 0, m_stall = 0;
  logic [7:0] m_od = 8'h00;
  bit         m_rdy, m_acc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_ov = 0; m_to = 0; m_grant = 0; m_ptr = 0; m_stall = 0; m_od = 8'h00;
    end else begin
      m_rdy = m_busy && (!m_ov || bus.o_tready);
      m_acc = m_rdy && bus.s_tvalid[m_grant];
      if (m_acc) begin
        m_ov = 1;
        m_od = bus.s_tdata[m_grant*8 +: 8];
      end else if (bus.o_tready) begin
        m_ov = 0;
      end
      m_to = 0;
      if (!m_busy) begin
        m_stall = 0;
        for (int k = 0; k < N; k++)
          if (!m_busy && bus.s_tvalid[(m_ptr + k) % N]) begin
            m_grant = (m_ptr + k) % N;
            m_busy  = 1;
          end
      end else if (m_acc) begin
        m_stall = 0;
        if (bus.s_tlast[m_grant]) begin
          m_busy = 0;
          m_ptr  = (m_grant + 1) % N;
        end
      end else if (TO_EN && !bus.s_tvalid[m_grant]) begin
        m_stall++;
        if (m_stall >= TO) begin
          m_busy  = 0;
          m_ptr   = (m_grant + 1) % N;
          m_to    = 1;
          m_stall = 0;
        end
      end
    end
  end

  logic [N-1:0] exp_rdy;
  always @(negedge clk) begin
    exp_rdy = (m_busy && (!m_ov || bus.o_tready)) ? (N'(1) << m_grant) : '0;
    chk("s_tready",  32'(bus.s_tready),  32'(exp_rdy));
    chk("o_tvalid",  32'(bus.o_tvalid),  32'(m_ov));
    chk("o_tdata",   32'(bus.o_tdata),   32'(m_od));
    chk("o_grant",   32'(bus.o_grant),   32'(m_grant));
    chk("o_busy",    32'(bus.o_busy),    32'(m_busy));
    chk("o_timeout", 32'(bus.o_timeout), 32'(m_to));
  end

  // Observed byte stream and grant sequence.
  logic [7:0] out_log [$];
  int         grant_log [$];
  logic [7:0] exp_b [$];
  int         exp_g [$];
  bit         prev_busy = 1'b0;

  always @(negedge clk) begin
    if (!rst && bus.o_tvalid && bus.o_tready) out_log.push_back(bus.o_tdata);
    if (!rst && bus.o_busy && !prev_busy) grant_log.push_back(int'(bus.o_grant));
    prev_busy = bus.o_busy;
  end

  task automatic check_logs(input string nm);
    chk({nm, " byte count"}, 32'(out_log.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < out_log.size(); i++)
      chk({nm, " byte"}, 32'(out_log[i]), 32'(exp_b[i]));
    chk({nm, " grant count"}, 32'(grant_log.size()), 32'(exp_g.size()));
    for (int i = 0; i < exp_g.size() && i < grant_log.size(); i++)
      chk({nm, " grant"}, 32'(grant_log[i]), 32'(exp_g[i]));
    out_log.delete(); grant_log.delete(); exp_b.delete(); exp_g.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    bit done;
    done = 0;
    for (int k = 0; k < maxc && !done; k++) begin
      @(negedge clk);
      done = !bus.o_busy && !bus.o_tvalid;
      for (int i = 0; i < N; i++) if (rd[i] != wr[i]) done = 0;
    end
    chk({nm, " drain bound"}, 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " busy"},    32'(bus.o_busy),    32'd0);
    chk({nm, " tvalid"},  32'(bus.o_tvalid),  32'd0);
    chk({nm, " tdata"},   32'(bus.o_tdata),   32'h00);
    chk({nm, " grant"},   32'(bus.o_grant),   32'd0);
    chk({nm, " tready"},  32'(bus.s_tready),  32'd0);
    chk({nm, " timeout"}, 32'(bus.o_timeout), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    for (int i = 0; i < N; i++) begin wr[i] = 0; rd[i] = 0; end
    bus.s_tvalid = '0;
    bus.s_tdata  = '0;
    bus.s_tlast  = '0;
    bus.o_tready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;
    bus.o_tready = 1'b1;

    // Contention from reset: whole messages in order 0,1,2.
    enq(0, 8'h10, 0); enq(0, 8'h11, 1);
    enq(1, 8'h20, 0); enq(1, 8'h21, 1);
    enq(2, 8'h30, 0); enq(2, 8'h31, 1);
    wait_idle("contention", 100);
    exp_b = {8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31};
    exp_g = {0, 1, 2};
    check_logs("contention");

    // Single requester 1.
    tick();
    enq(1, 8'h41, 0); enq(1, 8'h42, 1);
    wait_idle("single", 50);
    exp_b = {8'h41, 8'h42};
    exp_g = {1};
    check_logs("single");

    // Wrap-around: pointer is 2, only requester 0 asks.
    tick();
    enq(0, 8'h60, 1);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = bus.s_tvalid[0];
    end
    chk("wrap request seen", 32'(seen), 32'd1);
    chk("wrap idle cycle busy", 32'(bus.o_busy), 32'd0);
    @(negedge clk);
    chk("wrap grant", 32'(bus.o_grant), 32'd0);
    chk("wrap busy", 32'(bus.o_busy), 32'd1);
    wait_idle("wrap", 50);
    exp_b = {8'h60};
    exp_g = {0};
    check_logs("wrap");

    // Backpressure: sink stalls 10 cycles with 0x55 held.
    tick();
    bus.o_tready = 1'b0;
    enq(2, 8'h55, 0); enq(2, 8'h56, 0); enq(2, 8'h57, 1);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = bus.o_tvalid;
    end
    chk("bp tvalid seen", 32'(seen), 32'd1);
    for (int j = 0; j < 10; j++) begin
      chk("bp tdata held", 32'(bus.o_tdata), 32'h55);
      chk("bp ready low", 32'(bus.s_tready[2]), 32'd0);
      chk("bp tvalid held", 32'(bus.o_tvalid), 32'd1);
      @(negedge clk);
    end
    tick();
    bus.o_tready = 1'b1;
    wait_idle("backpressure", 50);
    exp_b = {8'h55, 8'h56, 8'h57};
    exp_g = {2};
    check_logs("backpressure");

    // Grant held through a long message while another requester waits.
    tick();
    enq(0, 8'h70, 0); enq(0, 8'h71, 0); enq(0, 8'h72, 0); enq(0, 8'h73, 1);
    enq(1, 8'h80, 1);
    wait_idle("hold", 60);
    exp_b = {8'h70, 8'h71, 8'h72, 8'h73, 8'h80};
    exp_g = {0, 1};
    check_logs("hold");

    // Stalled requester 0 (no tlast) with requester 1 waiting.
    tick();
    enq(0, 8'h90, 0);
    enq(1, 8'hA0, 1);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = bus.s_tvalid[0] && bus.s_tready[0];
    end
    chk("stall accept seen", 32'(seen), 32'd1);
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    n = 0;
    for (int k = 1; k <= 40 && n == 0; k++) begin
      @(negedge clk);
      if (bus.o_timeout) n = k;
    end
    chk("timeout delay", 32'(n), 32'd17);
    wait_idle("timeout", 60);
    exp_b = {8'h90, 8'hA0};
    exp_g = {0, 1};
    check_logs("timeout");
`else
    repeat (30) @(negedge clk);
    chk("no-timeout busy", 32'(bus.o_busy), 32'd1);
    chk("no-timeout grant", 32'(bus.o_grant), 32'd0);
    chk("no-timeout pulse", 32'(bus.o_timeout), 32'd0);
    tick();
    enq(0, 8'h91, 1);
    wait_idle("no-timeout", 60);
    exp_b = {8'h90, 8'h91, 8'hA0};
    exp_g = {0, 1};
    check_logs("no-timeout");
`endif

    // Reset after the second of four bytes.
    tick();
    enq(2, 8'hB0, 0); enq(2, 8'hB1, 0); enq(2, 8'hB2, 0); enq(2, 8'hB3, 1);
    enq(1, 8'hC0, 1);
    n = 0;
    for (int k = 0; k < 50 && n < 2; k++) begin
      @(negedge clk);
      if (bus.s_tvalid[2] && bus.s_tready[2]) n++;
    end
    chk("reset-mid accepts", 32'(n), 32'd2);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset-mid");
    tick();
    rst = 1'b0;
    wait_idle("reset-mid", 60);
    exp_b = {8'hB0, 8'hC0, 8'hB2, 8'hB3};
    exp_g = {2, 1, 2};
    check_logs("reset-mid");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
